// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings, immediate
// formats and the ID/EX pipeline bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_src_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        illegal;
    result_src_t result_src;
    alu_ctrl_t   alu_control;
  } id_ex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_src_t src);
    case (src)
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 integer register file: two combinational reads, one write,
// x0 hardwired to zero and same-cycle write-through to the read ports.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic        we3,
  input  logic [4:0]  a3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];
  logic        wr_en;

  assign wr_en = we3 && (a3 != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  // Bypass lets a WB write and a decode read of the same register share a cycle.
  always_comb begin
    if (a1 == 5'd0)                rd1 = '0;
    else if (wr_en && (a1 == a3))  rd1 = wd3;
    else                           rd1 = regs[a1];

    if (a2 == 5'd0)                rd2 = '0;
    else if (wr_en && (a2 == a3))  rd2 = wd3;
    else                           rd2 = regs[a2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, main/ALU decoders,
// immediate generation and the ID/EX register feeding execute.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_plus4_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        flush_e,
  input  logic        reg_write_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_ext_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic        jump_e,
  output logic        branch_e,
  output logic        alu_src_e,
  output logic        illegal_e,
  output logic [1:0]  result_src_e,
  output logic [2:0]  alu_control_e
);

  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic [31:0] rd1_d, rd2_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_decode;
  id_ex_t      id_ex_d, id_ex_q;

  always_ff @(posedge clk) begin
    if (rst || flush_d) begin
      instr_d    <= '0;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (!stall_d) begin
      instr_d    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
    end
  end

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .a1  (rs1_d),
    .a2  (rs2_d),
    .we3 (reg_write_w),
    .a3  (rd_w),
    .wd3 (result_w),
    .rd1 (rd1_d),
    .rd2 (rd2_d)
  );

  always_comb begin
    id_ex_d          = '0;
    alu_decode       = 1'b0;
    id_ex_d.rd1      = rd1_d;
    id_ex_d.rd2      = rd2_d;
    id_ex_d.pc       = pc_d;
    id_ex_d.pc_plus4 = pc_plus4_d;
    id_ex_d.rs1      = rs1_d;
    id_ex_d.rs2      = rs2_d;
    id_ex_d.rd       = instr_d[11:7];

    case (opcode)
      OP_LOAD: begin
        id_ex_d.reg_write  = 1'b1;
        id_ex_d.alu_src    = 1'b1;
        id_ex_d.result_src = RES_MEM;
        id_ex_d.imm_ext    = imm_gen(instr_d, IMM_I);
      end
      OP_STORE: begin
        id_ex_d.mem_write  = 1'b1;
        id_ex_d.alu_src    = 1'b1;
        id_ex_d.imm_ext    = imm_gen(instr_d, IMM_S);
      end
      OP_R: begin
        id_ex_d.reg_write  = 1'b1;
        alu_decode         = 1'b1;
      end
      OP_I: begin
        id_ex_d.reg_write  = 1'b1;
        id_ex_d.alu_src    = 1'b1;
        id_ex_d.imm_ext    = imm_gen(instr_d, IMM_I);
        alu_decode         = 1'b1;
      end
      OP_BRANCH: begin
        id_ex_d.branch      = 1'b1;
        id_ex_d.alu_control = ALU_SUB;
        id_ex_d.imm_ext     = imm_gen(instr_d, IMM_B);
      end
      OP_JAL: begin
        id_ex_d.jump       = 1'b1;
        id_ex_d.reg_write  = 1'b1;
        id_ex_d.result_src = RES_PC4;
        id_ex_d.imm_ext    = imm_gen(instr_d, IMM_J);
      end
      default: id_ex_d.illegal = 1'b1;
    endcase

    // An unsupported funct3 turns an otherwise legal ALU op into an illegal bubble.
    if (alu_decode) begin
      case (funct3)
        3'b000:  id_ex_d.alu_control = (opcode == OP_R && instr_d[30]) ? ALU_SUB : ALU_ADD;
        3'b010:  id_ex_d.alu_control = ALU_SLT;
        3'b110:  id_ex_d.alu_control = ALU_OR;
        3'b111:  id_ex_d.alu_control = ALU_AND;
        default: begin
          id_ex_d.reg_write = 1'b0;
          id_ex_d.alu_src   = 1'b0;
          id_ex_d.imm_ext   = '0;
          id_ex_d.illegal   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_e) id_ex_q <= '0;
    else                id_ex_q <= id_ex_d;
  end

  assign rd1_e         = id_ex_q.rd1;
  assign rd2_e         = id_ex_q.rd2;
  assign imm_ext_e     = id_ex_q.imm_ext;
  assign pc_e          = id_ex_q.pc;
  assign pc_plus4_e    = id_ex_q.pc_plus4;
  assign rs1_e         = id_ex_q.rs1;
  assign rs2_e         = id_ex_q.rs2;
  assign rd_e          = id_ex_q.rd;
  assign reg_write_e   = id_ex_q.reg_write;
  assign mem_write_e   = id_ex_q.mem_write;
  assign jump_e        = id_ex_q.jump;
  assign branch_e      = id_ex_q.branch;
  assign alu_src_e     = id_ex_q.alu_src;
  assign illegal_e     = id_ex_q.illegal;
  assign result_src_e  = id_ex_q.result_src;
  assign alu_control_e = id_ex_q.alu_control;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal cases plus a
// randomized run compared every cycle against a behavioural model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_f, pc_f, pc_plus4_f;
  logic        stall_d, flush_d, flush_e;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [4:0]  rs1_d, rs2_d;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, illegal_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_src_e(alu_src_e), .illegal_e(illegal_e),
    .result_src_e(result_src_e), .alu_control_e(alu_control_e)
  );

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, j, br, asrc, ill;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
  } ex_t;

  ex_t dut_ex;
  assign dut_ex = {rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
                   reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, illegal_e,
                   result_src_e, alu_control_e};

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc, m_pc4;
  ex_t         m_ex;
  bit          started = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0020_81B3;
  localparam logic [31:0] SUB = 32'h4020_81B3;

  // Arithmetic right shift of a left-justified field gives its sign-extended value.
  function automatic logic [31:0] sext_top(input logic [31:0] t, input int unsigned sh);
    logic signed [31:0] s;
    s = t;
    return s >>> sh;
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (reg_write_w && rd_w == idx) return result_w;
    return m_regs[idx];
  endfunction

  function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] pc4, input logic [31:0] a,
                                       input logic [31:0] b);
    ex_t e;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [2:0] f3;
    e = '0;
    e.rd1 = a; e.rd2 = b; e.pc = pc; e.pc4 = pc4;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    f3    = ins[14:12];
    imm_i = sext_top(ins, 20);
    imm_s = sext_top({ins[31:25], ins[11:7], 20'h0}, 20);
    imm_b = sext_top({ins[31], ins[7], ins[30:25], ins[11:8], 20'h0}, 19);
    imm_j = sext_top({ins[31], ins[19:12], ins[20], ins[30:21], 12'h0}, 11);
    case (ins[6:0])
      7'b0000011: begin e.rw = 1; e.asrc = 1; e.rsrc = 2'd1; e.imm = imm_i; end
      7'b0100011: begin e.mw = 1; e.asrc = 1; e.imm = imm_s; end
      7'b1100011: begin e.br = 1; e.alu = 3'd1; e.imm = imm_b; end
      7'b1101111: begin e.j = 1; e.rw = 1; e.rsrc = 2'd2; e.imm = imm_j; end
      7'b0110011, 7'b0010011: begin
        if (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7) begin
          e.rw = 1;
          if (ins[6:0] == 7'b0010011) begin e.asrc = 1; e.imm = imm_i; end
          if (f3 == 3'd2)      e.alu = 3'd5;
          else if (f3 == 3'd6) e.alu = 3'd3;
          else if (f3 == 3'd7) e.alu = 3'd2;
          else                 e.alu = (ins[6:0] == 7'b0110011 && ins[30]) ? 3'd1 : 3'd0;
        end else begin
          e.ill = 1;
        end
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst) begin
      started <= 1'b1;
      m_ex    <= '0;
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_instr <= '0; m_pc <= '0; m_pc4 <= '0;
    end else begin
      if (flush_e) m_ex <= '0;
      else m_ex <= model_decode(m_instr, m_pc, m_pc4, rdreg(m_instr[19:15]), rdreg(m_instr[24:20]));
      if (reg_write_w && rd_w != 0) m_regs[rd_w] <= result_w;
      if (flush_d) begin
        m_instr <= '0; m_pc <= '0; m_pc4 <= '0;
      end else if (!stall_d) begin
        m_instr <= instr_f; m_pc <= pc_f; m_pc4 <= pc_plus4_f;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (dut_ex !== m_ex) begin
        errors++;
        $display("FAIL ex_bundle cycle %0d got %h want %h", cycle, dut_ex, m_ex);
      end
      checks++;
      if ({rs1_d, rs2_d} !== {m_instr[19:15], m_instr[24:20]}) begin
        errors++;
        $display("FAIL rs_d cycle %0d got %h/%h want %h/%h", cycle, rs1_d, rs2_d,
                 m_instr[19:15], m_instr[24:20]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] pc_cnt = 32'h100;

  task automatic load(input logic [31:0] ins);
    instr_f    = ins;
    pc_f       = pc_cnt;
    pc_plus4_f = pc_cnt + 32'd4;
    pc_cnt     = pc_cnt + 32'd4;
  endtask

  task automatic issue(input logic [31:0] ins);
    load(ins);
    tick();
    load(NOP);
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 8))
      0: ins[6:0] = 7'b0000011;
      1: ins[6:0] = 7'b0100011;
      2, 3: ins[6:0] = 7'b0110011;
      4: ins[6:0] = 7'b0010011;
      5: ins[6:0] = 7'b1100011;
      6: ins[6:0] = 7'b1101111;
      7: ins = 32'd0;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 0) ins[19:15] = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 0) ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  initial begin
    rst = 1; instr_f = '0; pc_f = '0; pc_plus4_f = '0;
    stall_d = 0; flush_d = 0; flush_e = 0;
    reg_write_w = 0; rd_w = '0; result_w = '0;
    tick(); tick();
    chk("reset_zero", {31'd0, |dut_ex}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_e}, 32'd0);

    rst = 0;
    reg_write_w = 1; rd_w = 5'd1; result_w = 32'd5; load(NOP); tick();
    rd_w = 5'd2; result_w = 32'd7; tick();
    reg_write_w = 0;

    issue(ADD);
    chk("add_alu", {29'd0, alu_control_e}, 32'd0);
    chk("add_rw", {31'd0, reg_write_e}, 32'd1);
    chk("add_rd1", rd1_e, 32'd5);
    chk("add_rd2", rd2_e, 32'd7);
    chk("add_regs", {17'd0, rs1_e, rs2_e, rd_e}, {17'd0, 5'd1, 5'd2, 5'd3});

    issue(SUB);
    chk("sub_alu", {29'd0, alu_control_e}, 32'd1);

    issue(32'h0030_A213);
    chk("slti_alu", {29'd0, alu_control_e}, 32'd5);
    chk("slti_src", {31'd0, alu_src_e}, 32'd1);
    chk("slti_imm", imm_ext_e, 32'd3);

    issue(32'hFFC1_2283);
    chk("lw_imm", imm_ext_e, 32'hFFFF_FFFC);
    chk("lw_rsrc", {30'd0, result_src_e}, 32'd1);
    chk("lw_src", {31'd0, alu_src_e}, 32'd1);

    issue(32'hFE20_8CE3);
    chk("beq_br", {31'd0, branch_e}, 32'd1);
    chk("beq_alu", {29'd0, alu_control_e}, 32'd1);
    chk("beq_imm", imm_ext_e, 32'hFFFF_FFF8);

    issue(32'h0080_00EF);
    chk("jal_ctl", {28'd0, jump_e, reg_write_e, result_src_e}, 32'b1110);
    chk("jal_imm", imm_ext_e, 32'd8);

    load(ADD); tick();
    reg_write_w = 1; rd_w = 5'd1; result_w = 32'hDEAD_BEEF; load(NOP); tick();
    reg_write_w = 0;
    chk("bypass_rd1", rd1_e, 32'hDEAD_BEEF);
    chk("bypass_rd2", rd2_e, 32'd7);

    reg_write_w = 1; rd_w = 5'd0; result_w = 32'h1234_5678;
    issue(32'h0000_01B3);
    reg_write_w = 0;
    chk("x0_rd1", rd1_e, 32'd0);
    chk("x0_rd2", rd2_e, 32'd0);

    load(SUB); tick();
    stall_d = 1; flush_e = 1; load(NOP); tick();
    chk("stall_bubble", {31'd0, |dut_ex}, 32'd0);
    tick();
    chk("stall_hold", {22'd0, rs1_d, rs2_d}, {22'd0, 5'd1, 5'd2});
    stall_d = 0; flush_e = 0; tick();
    chk("stall_release", {29'd0, alu_control_e}, 32'd1);

    load(ADD); tick();
    stall_d = 1; flush_d = 1; load(NOP); tick();
    chk("flush_wins", {27'd0, rs1_d}, 32'd0);
    stall_d = 0; flush_d = 0; tick();
    chk("zero_illegal", {31'd0, illegal_e}, 32'd1);
    chk("zero_ctl", {24'd0, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, result_src_e, 1'b0},
        32'd0);

    issue(32'h0020_91B3);
    chk("badf3_ill", {31'd0, illegal_e}, 32'd1);
    chk("badf3_rw", {31'd0, reg_write_e}, 32'd0);

    rst = 1; load(ADD); tick();
    chk("midrst_zero", {31'd0, |dut_ex}, 32'd0);
    rst = 0;
    issue(ADD);
    chk("midrst_rd1", rd1_e, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      load(rand_instr());
      pc_f        = $urandom;
      pc_plus4_f  = pc_f + 32'd4;
      stall_d     = ($urandom_range(0, 9) == 0);
      flush_d     = ($urandom_range(0, 14) == 0);
      flush_e     = stall_d | ($urandom_range(0, 14) == 0);
      reg_write_w = 1'($urandom_range(0, 1));
      rd_w        = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      result_w    = $urandom;
      rst         = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
